// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  function automatic int wofs_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int line_words);
    return addr_w - 2 - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Cache data array: one synchronous write port, one combinational read port.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 8,
  localparam int IDX_W     = idx_w(NUM_LINES),
  localparam int WOFS_W    = wofs_w(LINE_WORDS)
) (
  input  logic              mem_clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFS_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WOFS_W-1:0] rd_word,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [NUM_LINES*LINE_WORDS];

  always_ff @(posedge mem_clk) begin
    if (we) mem[{wr_idx, wr_word}] <= wr_data;
  end

  assign rd_data = mem[{rd_idx, rd_word}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped I-cache with word-serial refill, hit-under-miss and flush.
// Optional hit/miss counters when ICACHE_PERF_CNT_EN is defined.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              mem_clk,
  input  logic              i_rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_valid,
  output logic [31:0]       cpu_data,
  input  logic              flush,
  output logic              busy,
  output logic              mem_rd_rq,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_beat_valid,
  input  logic [31:0]       mem_rd_beat_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int WOFS_W   = wofs_w(LINE_WORDS);
  localparam int IDX_W    = idx_w(NUM_LINES);
  localparam int TAG_W    = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
  localparam int LINE_LSB = 2 + WOFS_W;

  state_e                          state, state_nxt;
  logic [NUM_LINES-1:0]            valid;
  logic [NUM_LINES-1:0][TAG_W-1:0] tags;
  logic [WOFS_W-1:0]               beat_cnt;
  logic                            flush_pend;
  logic [IDX_W-1:0]                miss_idx;
  logic [TAG_W-1:0]                miss_tag;

  logic [WOFS_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit, start_miss, beat_we, last_beat;
  logic [31:0]       rd_data;
  logic              unused_byte_ofs;

  assign req_word        = cpu_addr[2 +: WOFS_W];
  assign req_idx         = cpu_addr[LINE_LSB +: IDX_W];
  assign req_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_ofs = ^cpu_addr[1:0];

  // The line under refill had its valid bit dropped at miss time, so it cannot hit early.
  assign hit       = cpu_req & valid[req_idx] & (tags[req_idx] == req_tag);
  assign cpu_valid = hit;
  assign cpu_data  = hit ? rd_data : '0;

  assign busy        = (state != IDLE);
  assign mem_rd_rq   = (state == REQ);
  assign mem_rd_addr = mem_rd_rq ? {miss_tag, miss_idx, {LINE_LSB{1'b0}}} : '0;

  always_comb begin
    state_nxt  = state;
    start_miss = 1'b0;
    beat_we    = 1'b0;
    last_beat  = 1'b0;
    case (state)
      IDLE: if (cpu_req && !hit && !flush) begin
        start_miss = 1'b1;
        state_nxt  = REQ;
      end
      REQ:  if (mem_rd_ack) state_nxt = FILL;
      FILL: if (mem_rd_beat_valid) begin
        beat_we = 1'b1;
        if (beat_cnt == WOFS_W'(LINE_WORDS-1)) begin
          last_beat = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      valid      <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == REQ && mem_rd_ack) beat_cnt <= '0;
      else if (beat_we)               beat_cnt <= beat_cnt + 1'b1;

      if (state == IDLE && flush)  valid <= '0;
      else if (start_miss)         valid[req_idx] <= 1'b0;
      else if (last_beat) begin
        if (flush_pend || flush)   valid <= '0;
        else                       valid[miss_idx] <= 1'b1;
      end

      // A flush seen mid-refill is deferred to the end of the bus transfer.
      if (last_beat)                    flush_pend <= 1'b0;
      else if (flush && state != IDLE)  flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (start_miss) begin
      miss_idx <= req_idx;
      miss_tag <= req_tag;
    end
    if (last_beat) tags[miss_idx] <= miss_tag;
  end

  icache_line_ram #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_ram (
    .mem_clk (mem_clk),
    .we      (beat_we),
    .wr_idx  (miss_idx),
    .wr_word (beat_cnt),
    .wr_data (mem_rd_beat_data),
    .rd_idx  (req_idx),
    .rd_word (req_word),
    .rd_data (rd_data)
  );

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge mem_clk or posedge i_rst) begin
    if (i_rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)        hit_cnt  <= hit_cnt + 32'd1;
      if (start_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm (4 lines x 4 words): refill, conflict, hit-under-miss, flush, reset.
module tb_icache_dm;
  localparam int NL = 4;
  localparam int LW = 4;
  localparam int AW = 32;

  logic          mem_clk = 1'b0;
  logic          i_rst, cpu_req, flush, mem_rd_ack, mem_rd_beat_valid;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   mem_rd_beat_data;
  logic          cpu_valid, busy, mem_rd_rq;
  logic [31:0]   cpu_data;
  logic [AW-1:0] mem_rd_addr;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 mem_clk = ~mem_clk;

  icache_dm #(.NUM_LINES(NL), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .mem_clk           (mem_clk),
    .i_rst             (i_rst),
    .cpu_req           (cpu_req),
    .cpu_addr          (cpu_addr),
    .cpu_valid         (cpu_valid),
    .cpu_data          (cpu_data),
    .flush             (flush),
    .busy              (busy),
    .mem_rd_rq         (mem_rd_rq),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_ack        (mem_rd_ack),
    .mem_rd_beat_valid (mem_rd_beat_valid),
    .mem_rd_beat_data  (mem_rd_beat_data)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt)
`endif
  );

  // Backing-store word: generation byte on top so each refill returns distinguishable data.
  function automatic logic [31:0] mw(input logic [31:0] a, input logic [7:0] g);
    return {g, a[23:0]} ^ 32'h005A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge mem_clk);
  endtask

  // One fetch cycle; a hit's expected word goes through the scoreboard queue.
  task automatic lookup(input string tag, input logic [31:0] a, input bit exp_hit,
                        input logic [31:0] d);
    logic [31:0] e;
    cpu_req  = 1'b1;
    cpu_addr = a;
    if (exp_hit) exp_q.push_back(d);
    #1;
    chk({tag, ".v"}, 32'(cpu_valid), 32'(exp_hit));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".d"}, cpu_data, e);
    end else begin
      chk({tag, ".d"}, cpu_data, 32'h0);
    end
    tick();
  endtask

  // Serves the outstanding line request; optional flush / reset / hit-under-miss at a beat index.
  task automatic refill(input logic [31:0] line, input logic [7:0] g, input int ack_wait,
                        input int flush_at, input int rst_at, input int hum_at,
                        input logic [31:0] hum_addr, input logic [31:0] hum_d);
    int n = 0;
    cpu_req = 1'b0;
    #1;
    while (!mem_rd_rq && n < 20) begin
      tick(); #1; n++;
    end
    chk("rq", 32'(mem_rd_rq), 32'h1);
    chk("rq_addr", mem_rd_addr, line);
    chk("busy_req", 32'(busy), 32'h1);
    for (int k = 0; k < ack_wait; k++) begin
      mem_rd_beat_valid = 1'b1;
      mem_rd_beat_data  = 32'hDEAD_0000 | k;
      tick(); #1;
      chk("rq_hold", 32'(mem_rd_rq), 32'h1);
      chk("rq_addr_hold", mem_rd_addr, line);
    end
    mem_rd_beat_valid = 1'b0;
    mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0;
    for (int b = 0; b < LW; b++) begin
      if (b == rst_at) begin
        i_rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rq", 32'(mem_rd_rq), 32'h0);
        chk("rst_addr", mem_rd_addr, 32'h0);
        tick();
        i_rst = 1'b0;
        for (int s = b; s < LW; s++) begin
          mem_rd_beat_valid = 1'b1;
          mem_rd_beat_data  = 32'hBAD0_0000 | s;
          tick();
        end
        mem_rd_beat_valid = 1'b0;
        return;
      end
      if (b == 0) begin
        chk("fill_rq", 32'(mem_rd_rq), 32'h0);
        chk("fill_addr", mem_rd_addr, 32'h0);
        chk("fill_busy", 32'(busy), 32'h1);
      end
      mem_rd_beat_valid = 1'b1;
      mem_rd_beat_data  = mw(line + 4*b, g);
      flush = (b == flush_at);
      if (b == hum_at) begin
        chk("hum_busy", 32'(busy), 32'h1);
        lookup("hum", hum_addr, 1'b1, hum_d);
        cpu_req = 1'b0;
      end else if (b == LW-1) begin
        lookup("fill_self", line, 1'b0, 32'h0);
        cpu_req = 1'b0;
      end else begin
        tick();
      end
    end
    mem_rd_beat_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h100; flush = 1'b0;
    mem_rd_ack = 1'b0; mem_rd_beat_valid = 1'b0; mem_rd_beat_data = '0;
    repeat (2) tick();
    #1;
    chk("rst_cpu_valid", 32'(cpu_valid), 32'h0);
    chk("rst_cpu_data", cpu_data, 32'h0);
    chk("rst_busy0", 32'(busy), 32'h0);
    chk("rst_rq0", 32'(mem_rd_rq), 32'h0);
    chk("rst_addr0", mem_rd_addr, 32'h0);
    cpu_req = 1'b0;
    tick();
    i_rst = 1'b0;

    // cold miss, 2-cycle ack wait
    lookup("cold_miss", 32'h100, 1'b0, 0);
    refill(32'h100, 8'd1, 2, -1, -1, -1, 0, 0);
    lookup("cold_hit0", 32'h100, 1'b1, mw(32'h100, 8'd1));
    lookup("cold_hit3", 32'h10C, 1'b1, mw(32'h10C, 8'd1));

    // conflict on index 0
    lookup("conf_miss", 32'h140, 1'b0, 0);
    refill(32'h140, 8'd2, 0, -1, -1, -1, 0, 0);
    lookup("conf_hit", 32'h144, 1'b1, mw(32'h144, 8'd2));
    lookup("conf_remiss", 32'h100, 1'b0, 0);
    refill(32'h100, 8'd3, 0, -1, -1, -1, 0, 0);
    lookup("conf_rehit", 32'h108, 1'b1, mw(32'h108, 8'd3));

    // flush in IDLE together with a miss: flush wins, miss follows
    flush = 1'b1;
    lookup("fl_idle_miss", 32'h120, 1'b0, 0);
    flush = 1'b0;
    chk("fl_idle_busy", 32'(busy), 32'h0);
    lookup("fl_idle_miss2", 32'h120, 1'b0, 0);
    lookup("fl_cleared", 32'h100, 1'b0, 0);
    refill(32'h120, 8'd5, 1, -1, -1, -1, 0, 0);
    lookup("fl_fill_hit", 32'h12C, 1'b1, mw(32'h12C, 8'd5));

    // hit-under-miss
    lookup("hum_miss0", 32'h110, 1'b0, 0);
    refill(32'h110, 8'd6, 0, -1, -1, -1, 0, 0);
    lookup("hum_miss1", 32'h100, 1'b0, 0);
    refill(32'h100, 8'd7, 0, -1, -1, 1, 32'h114, mw(32'h114, 8'd6));
    lookup("hum_done", 32'h100, 1'b1, mw(32'h100, 8'd7));

    // flush during FILL
    lookup("ff_miss", 32'h130, 1'b0, 0);
    refill(32'h130, 8'd8, 0, 1, -1, -1, 0, 0);
    lookup("ff_100", 32'h100, 1'b0, 0);
    lookup("ff_110", 32'h110, 1'b0, 0);
    lookup("ff_130", 32'h130, 1'b0, 0);
    refill(32'h100, 8'd9, 0, -1, -1, -1, 0, 0);
    lookup("ff_after", 32'h104, 1'b1, mw(32'h104, 8'd9));

    // reset mid-FILL, then stray beats in IDLE
    lookup("rs_miss", 32'h110, 1'b0, 0);
    refill(32'h110, 8'd10, 0, -1, 2, -1, 0, 0);
    lookup("rs_100", 32'h100, 1'b0, 0);
    refill(32'h100, 8'd11, 1, -1, -1, -1, 0, 0);
    lookup("rs_fresh", 32'h10C, 1'b1, mw(32'h10C, 8'd11));
    lookup("rs_110", 32'h110, 1'b0, 0);
    refill(32'h110, 8'd12, 0, -1, -1, -1, 0, 0);
    lookup("rs_110_hit", 32'h118, 1'b1, mw(32'h118, 8'd12));
    cpu_req = 1'b0;

`ifdef ICACHE_PERF_CNT_EN
    i_rst = 1'b1;
    #1;
    chk("perf_rst_hit", hit_cnt, 32'h0);
    chk("perf_rst_miss", miss_cnt, 32'h0);
    tick();
    i_rst = 1'b0;
    lookup("perf_m0", 32'h100, 1'b0, 0);
    refill(32'h100, 8'd13, 0, -1, -1, -1, 0, 0);
    for (int i = 0; i < 3; i++)
      lookup("perf_h0", 32'h100 + 4*i, 1'b1, mw(32'h100 + 4*i, 8'd13));
    lookup("perf_m1", 32'h110, 1'b0, 0);
    refill(32'h110, 8'd14, 0, -1, -1, -1, 0, 0);
    for (int i = 0; i < 2; i++)
      lookup("perf_h1", 32'h110 + 4*i, 1'b1, mw(32'h110 + 4*i, 8'd14));
    cpu_req = 1'b0;
    #1;
    chk("perf_hit", hit_cnt, 32'd5);
    chk("perf_miss", miss_cnt, 32'd2);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
